lighthouse_ootx_decoder: RTL and testbench
==========================================

// Module: lighthouse_ootx_decoder
// PURPOSE
//  Downstream of lighthouse_sensor: consumes the per-sweep OOTX data bit decoded from one sync pulse (one instance per
//  ootx[n] bit) and reassembles the base-station OOTX frame. Hunts the preamble, strips stuffing bits, extracts the
//  length, streams payload bytes to the consumer (UART hex dumper / config RAM) and checks the CRC32.
// PARAMETERS
//  MAX_LEN        64   largest accepted payload length in bytes; longer lengths abort the frame
//  PREAMBLE_ZEROS 17   consecutive zero bits required before the frame-start 1 bit
// PORTS
//  clk           in   1   system clock (48 MHz)
//  reset         in   1   asynchronous, active-high reset
//  bit_strobe    in   1   one-cycle pulse: bit_data is valid (one per valid sync pulse)
//  bit_data      in   1   OOTX data bit
//  byte_data     out  8   payload byte, valid with byte_strobe
//  byte_strobe   out  1   one-cycle pulse per payload byte (padding and CRC bytes are not emitted)
//  frame_start   out  1   one-cycle pulse when a length word <= MAX_LEN is accepted
//  frame_len     out  16  payload length of the current/last frame, valid from frame_start
//  frame_done    out  1   one-cycle pulse when the last CRC bit has been received
//  frame_crc_ok  out  1   registered with frame_done, holds until next frame_start; 1 = CRC matched
//  frame_error   out  1   one-cycle pulse on stuffing-bit error or oversize length
// BEHAVIOUR
//  - Reset (async): all outputs 0, state HUNT, all counters, shift register and CRC cleared. Reset mid-frame discards it.
//  - Only bit_strobe advances state. Strobes are guaranteed >= 2 clk apart. All outputs are registered.
//  - Every output pulse appears exactly 1 cycle after the bit_strobe that completes the event.
//  - HUNT: zero_cnt counts consecutive 0 bits, saturating at PREAMBLE_ZEROS. A 1 with zero_cnt == PREAMBLE_ZEROS
//    -> LEN, word bit count = 0. A 1 otherwise -> zero_cnt = 0.
//  - Word framing, outside HUNT: 16 data bits, MSB first. First received byte = word[15:8], second = word[7:0].
//    Each word is followed by one stuffing bit that must be 1.
//  - Stuffing-bit error: a stuffing bit of 0 pulses frame_error. It then goes to HUNT with zero_cnt = 1, because that
//    zero counts toward the next preamble.
//  - LEN: one word, little-endian, so frame_len = {second byte, first byte}.
//    - If the length > MAX_LEN: frame_error, then HUNT with zero_cnt = 0.
//    - Otherwise: frame_start, CRC reset to 0xFFFFFFFF, then PAYLOAD; go to CRC directly if the length is 0.
//  - PAYLOAD: each completed byte is emitted on byte_data/byte_strobe and folded into the CRC.
//    - An odd length is padded to a whole word. The pad byte is consumed but neither emitted nor folded into the CRC.
//    - After the word holding the last payload byte and its stuffing bit -> CRC.
//  - CRC: IEEE CRC32, reflected (poly 0xEDB88320), init 0xFFFFFFFF, final XOR 0xFFFFFFFF, over the payload bytes only.
//    - Each byte is folded LSB first; the update is done in the cycle after the byte completes.
//    - Received CRC is 2 words = 4 bytes, little-endian (first byte = CRC[7:0]).
//    - On the 32nd CRC data bit: frame_done = 1, frame_crc_ok = (rx == computed). Then HUNT with zero_cnt = 0.
//      The trailing stuffing bit is seen in HUNT as a harmless 1.
//  - Length 0: computed CRC = 0x00000000.
//  - frame_len holds until the next accepted length word.
//  - frame_error and frame_done are never pulsed for the same frame.
// TESTING
//  1. 17x0, 1, length 0x0009, payload "123456789", pad 0x00, CRC bytes 26 39 F4 CB, all stuffing bits 1
//     -> frame_start; frame_len = 9; byte_strobe x9 with 31..39; frame_done with frame_crc_ok = 1.
//  2. Same frame with CRC byte 0x26 sent as 0x27 -> 9 bytes emitted, frame_done with frame_crc_ok = 0, no frame_error.
//  3. Same frame with the stuffing bit after payload word 2 set to 0 -> frame_error, only 4 bytes emitted, no frame_done.
//     The same frame sent immediately after decodes with crc_ok = 1.
//  4. 17x0, 1, length 0x00FF -> frame_error, no frame_start, frame_len unchanged. Back-to-back test 1 frame then passes.
//  5. 16x0, 1, then test-1 frame body without a preamble -> no frame_start, no byte_strobe.
//     Length 0: 17x0, 1, 0x0000, CRC 00 00 00 00 -> frame_start, frame_done with crc_ok = 1, no byte_strobe.
//  6. Assert reset for 1 cycle after payload byte 5 of test 1 -> all outputs 0 immediately, no frame_done.
//     A following full frame decodes with crc_ok = 1.

Source files
------------

// File: rtl/lighthouse_ootx_decoder_if.sv
// Bit-stream input and frame/byte outputs of the lighthouse OOTX decoder.
// The master side feeds decoded sweep bits; the slave side is the decoder.
interface lighthouse_ootx_decoder_if;
  logic        bit_strobe;
  logic        bit_data;
  logic [7:0]  byte_data;
  logic        byte_strobe;
  logic        frame_start;
  logic [15:0] frame_len;
  logic        frame_done;
  logic        frame_crc_ok;
  logic        frame_error;

  modport master (
    output bit_strobe, bit_data,
    input  byte_data, byte_strobe, frame_start, frame_len,
    input  frame_done, frame_crc_ok, frame_error
  );

  modport slave (
    input  bit_strobe, bit_data,
    output byte_data, byte_strobe, frame_start, frame_len,
    output frame_done, frame_crc_ok, frame_error
  );
endinterface

// File: rtl/lighthouse_ootx_decoder.sv
// Reassembles the base-station OOTX frame from one-bit-per-sweep data:
// preamble hunt, stuffing-bit removal, length word, payload byte stream and
// CRC32 check. Words are 16 bits MSB first, each followed by a stuffing 1.
module lighthouse_ootx_decoder #(
  parameter int MAX_LEN        = 64,
  parameter int PREAMBLE_ZEROS = 17
) (
  input  logic                      clk,
  input  logic                      reset,
  lighthouse_ootx_decoder_if.slave  bus
);

  localparam int            ZW       = $clog2(PREAMBLE_ZEROS + 1);
  localparam logic [ZW-1:0] ZERO_MAX = ZW'(PREAMBLE_ZEROS);
  localparam logic [ZW-1:0] ZERO_ONE = ZW'(1);
  localparam logic [15:0]   LEN_MAX  = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CRC     = 2'd3
  } state_t;

  // Reflected IEEE CRC32 update of one byte, folded LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 32'hEDB88320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_t        state_r, state_s;
  logic [ZW-1:0] zero_cnt_r, zero_cnt_s;
  logic [4:0]    bit_cnt_r, bit_cnt_s;     // 0..15 data bits, 16 = stuffing bit
  logic [14:0]   shift_r, shift_s;         // previous 15 bits of the current word
  logic [15:0]   byte_idx_r, byte_idx_s;   // payload bytes consumed, pad included
  logic [15:0]   len_r, len_s;
  logic [31:0]   crc_r, crc_s;
  logic [23:0]   rx_r, rx_s;               // first three received CRC bytes
  logic          crc_word_r, crc_word_s;   // second CRC word in progress
  logic          fold_r, fold_s;           // a payload byte waits to be folded
  logic [7:0]    fold_byte_r, fold_byte_s;
  logic [7:0]    byte_data_r, byte_data_s;
  logic          byte_strobe_r, byte_strobe_s;
  logic          frame_start_r, frame_start_s;
  logic          frame_done_r, frame_done_s;
  logic          crc_ok_r, crc_ok_s;
  logic          frame_error_r, frame_error_s;
  logic [7:0]    byte_done_s;
  logic [15:0]   len_word_s;

  // Next-state, counters, CRC folding and output pulses.
  always_comb begin
    state_s       = state_r;
    zero_cnt_s    = zero_cnt_r;
    bit_cnt_s     = bit_cnt_r;
    shift_s       = shift_r;
    byte_idx_s    = byte_idx_r;
    len_s         = len_r;
    rx_s          = rx_r;
    crc_word_s    = crc_word_r;
    fold_s        = 1'b0;
    fold_byte_s   = fold_byte_r;
    byte_data_s   = byte_data_r;
    crc_ok_s      = crc_ok_r;
    byte_strobe_s = 1'b0;
    frame_start_s = 1'b0;
    frame_done_s  = 1'b0;
    frame_error_s = 1'b0;
    byte_done_s   = {shift_r[6:0], bus.bit_data};
    len_word_s    = {byte_done_s, shift_r[14:7]};
    if (fold_r) begin
      crc_s = crc32_byte(crc_r, fold_byte_r);
    end else begin
      crc_s = crc_r;
    end

    if (bus.bit_strobe) begin
      case (state_r)
        HUNT: begin
          if (!bus.bit_data) begin
            if (zero_cnt_r == ZERO_MAX) begin
              zero_cnt_s = zero_cnt_r;
            end else begin
              zero_cnt_s = zero_cnt_r + ZERO_ONE;
            end
          end else if (zero_cnt_r == ZERO_MAX) begin
            state_s    = LEN;
            bit_cnt_s  = 5'd0;
            zero_cnt_s = '0;
          end else begin
            zero_cnt_s = '0;
          end
        end
        LEN, PAYLOAD, CRC: begin
          if (bit_cnt_r == 5'd16) begin
            bit_cnt_s = 5'd0;
            if (!bus.bit_data) begin
              // This zero already counts toward the next preamble.
              frame_error_s = 1'b1;
              state_s       = HUNT;
              zero_cnt_s    = ZERO_ONE;
            end else if ((state_r == PAYLOAD) && (byte_idx_r >= len_r)) begin
              state_s = CRC;
            end else begin
              state_s = state_r;
            end
          end else begin
            shift_s   = {shift_r[13:0], bus.bit_data};
            bit_cnt_s = bit_cnt_r + 5'd1;
            if (bit_cnt_r[2:0] == 3'd7) begin
              case (state_r)
                LEN: begin
                  if (!bit_cnt_r[3]) begin
                    len_s = len_r;
                  end else if (len_word_s > LEN_MAX) begin
                    frame_error_s = 1'b1;
                    state_s       = HUNT;
                    zero_cnt_s    = '0;
                    bit_cnt_s     = 5'd0;
                  end else begin
                    frame_start_s = 1'b1;
                    len_s         = len_word_s;
                    crc_s         = 32'hFFFFFFFF;
                    byte_idx_s    = 16'd0;
                    crc_word_s    = 1'b0;
                    crc_ok_s      = 1'b0;
                    if (len_word_s == 16'd0) begin
                      state_s = CRC;
                    end else begin
                      state_s = PAYLOAD;
                    end
                  end
                end
                PAYLOAD: begin
                  // Bytes past the length are the pad byte: consumed silently.
                  if (byte_idx_r < len_r) begin
                    byte_data_s   = byte_done_s;
                    byte_strobe_s = 1'b1;
                    fold_s        = 1'b1;
                    fold_byte_s   = byte_done_s;
                  end else begin
                    byte_data_s = byte_data_r;
                  end
                  byte_idx_s = byte_idx_r + 16'd1;
                end
                CRC: begin
                  rx_s = {byte_done_s, rx_r[23:8]};
                  if (bit_cnt_r[3] && crc_word_r) begin
                    frame_done_s = 1'b1;
                    crc_ok_s     = ({byte_done_s, rx_r} == ~crc_r);
                    state_s      = HUNT;
                    zero_cnt_s   = '0;
                    bit_cnt_s    = 5'd0;
                  end else if (bit_cnt_r[3]) begin
                    crc_word_s = 1'b1;
                  end else begin
                    crc_word_s = crc_word_r;
                  end
                end
                default: begin
                  state_s = HUNT;
                end
              endcase
            end else begin
              byte_idx_s = byte_idx_r;
            end
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= HUNT;
      zero_cnt_r    <= '0;
      bit_cnt_r     <= 5'd0;
      shift_r       <= 15'd0;
      byte_idx_r    <= 16'd0;
      len_r         <= 16'd0;
      crc_r         <= 32'd0;
      rx_r          <= 24'd0;
      crc_word_r    <= 1'b0;
      fold_r        <= 1'b0;
      fold_byte_r   <= 8'd0;
      byte_data_r   <= 8'd0;
      byte_strobe_r <= 1'b0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      crc_ok_r      <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      zero_cnt_r    <= zero_cnt_s;
      bit_cnt_r     <= bit_cnt_s;
      shift_r       <= shift_s;
      byte_idx_r    <= byte_idx_s;
      len_r         <= len_s;
      crc_r         <= crc_s;
      rx_r          <= rx_s;
      crc_word_r    <= crc_word_s;
      fold_r        <= fold_s;
      fold_byte_r   <= fold_byte_s;
      byte_data_r   <= byte_data_s;
      byte_strobe_r <= byte_strobe_s;
      frame_start_r <= frame_start_s;
      frame_done_r  <= frame_done_s;
      crc_ok_r      <= crc_ok_s;
      frame_error_r <= frame_error_s;
    end
  end

  assign bus.byte_data    = byte_data_r;
  assign bus.byte_strobe  = byte_strobe_r;
  assign bus.frame_start  = frame_start_r;
  assign bus.frame_len    = len_r;
  assign bus.frame_done   = frame_done_r;
  assign bus.frame_crc_ok = crc_ok_r;
  assign bus.frame_error  = frame_error_r;

endmodule

// File: tb/tb_lighthouse_ootx_decoder.sv
// Directed bench for lighthouse_ootx_decoder: a table of whole frames with
// hand-computed outcomes, plus hand sequences for pulse timing and reset.
module tb_lighthouse_ootx_decoder;

  logic clk = 1'b0;
  logic reset;
  lighthouse_ootx_decoder_if bus ();

  lighthouse_ootx_decoder #(.MAX_LEN(64), .PREAMBLE_ZEROS(17)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pre;       // zeros before the start bit
    logic [15:0] len;       // length word sent
    int          n_pay;     // payload bytes 0x31+i sent; -1 = stop after length word
    logic [31:0] crc;       // CRC value sent, little-endian
    int          bad_word;  // word whose stuffing bit is 0 (0 = length word), -1 none
    int          e_start;
    int          e_bytes;
    int          e_done;
    int          e_ok;
    int          e_err;
    int          e_len;
  } vec_t;

  vec_t vecs [11];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_bytes = 0, n_start = 0, n_done = 0, n_err = 0;
  logic [7:0] byte_log [1024];

  // Count output pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.byte_strobe) begin
        if (n_bytes < 1024) byte_log[n_bytes] = bus.byte_data;
        n_bytes++;
      end
      if (bus.frame_start) n_start++;
      if (bus.frame_done)  n_done++;
      if (bus.frame_error) n_err++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One strobe; returns just after the sampling edge so pulses are visible.
  task automatic send_bit(input logic b);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.bit_strobe = 1'b1;
    bus.bit_data   = b;
    @(posedge clk);
    #1;
    bus.bit_strobe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0] bytes [$];
    repeat (v.pre) send_bit(1'b0);
    send_bit(1'b1);
    bytes.push_back(v.len[7:0]);
    bytes.push_back(v.len[15:8]);
    if (v.n_pay >= 0) begin
      for (int i = 0; i < v.n_pay; i++) bytes.push_back(8'(8'h31 + i));
      if (v.n_pay % 2 == 1) bytes.push_back(8'h00);
      bytes.push_back(v.crc[7:0]);
      bytes.push_back(v.crc[15:8]);
      bytes.push_back(v.crc[23:16]);
      bytes.push_back(v.crc[31:24]);
    end
    for (int w = 0; w < bytes.size() / 2; w++) begin
      send_byte(bytes[2*w]);
      send_byte(bytes[2*w+1]);
      if (w == v.bad_word) begin
        send_bit(1'b0);
        return;
      end
      send_bit(1'b1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int s0, b0, d0, e0, nb;
    s0 = n_start; b0 = n_bytes; d0 = n_done; e0 = n_err;
    send_frame(v);
    repeat (3) @(posedge clk);
    #1;
    nb = n_bytes - b0;
    chk({nm, " frame_start count"}, n_start - s0, v.e_start);
    chk({nm, " byte_strobe count"}, nb, v.e_bytes);
    if (nb == v.e_bytes) begin
      for (int i = 0; i < nb; i++)
        chk($sformatf("%s byte_data[%0d]", nm, i), int'(byte_log[b0+i]), 8'h31 + i);
    end
    chk({nm, " frame_done count"}, n_done - d0, v.e_done);
    if (v.e_done == 1) chk({nm, " frame_crc_ok"}, int'(bus.frame_crc_ok), v.e_ok);
    chk({nm, " frame_error count"}, n_err - e0, v.e_err);
    chk({nm, " frame_len"}, int'(bus.frame_len), v.e_len);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " byte_data"},    int'(bus.byte_data),    0);
    chk({nm, " byte_strobe"},  int'(bus.byte_strobe),  0);
    chk({nm, " frame_start"},  int'(bus.frame_start),  0);
    chk({nm, " frame_len"},    int'(bus.frame_len),    0);
    chk({nm, " frame_done"},   int'(bus.frame_done),   0);
    chk({nm, " frame_crc_ok"}, int'(bus.frame_crc_ok), 0);
    chk({nm, " frame_error"},  int'(bus.frame_error),  0);
  endtask

  initial begin
    int b0, d0;
    //          pre len     npay crc           bad st by dn ok er len
    vecs[0]  = '{17, 16'd9,   9, 32'hCBF43926, -1, 1, 9, 1, 1, 0, 9};   // good "123456789"
    vecs[1]  = '{17, 16'd9,   9, 32'hCBF43927, -1, 1, 9, 1, 0, 0, 9};   // first CRC byte 0x27
    vecs[2]  = '{17, 16'd9,   9, 32'hCBF43926,  2, 1, 4, 0, 0, 1, 9};   // bad stuffing after word 2
    vecs[3]  = '{16, 16'd9,   9, 32'hCBF43926, -1, 1, 9, 1, 1, 0, 9};   // error zero completes preamble
    vecs[4]  = '{17, 16'h00FF, -1, 32'h0,      -1, 0, 0, 0, 0, 1, 9};   // oversize length
    vecs[5]  = '{17, 16'd9,   9, 32'hCBF43926, -1, 1, 9, 1, 1, 0, 9};   // back-to-back good frame
    vecs[6]  = '{16, 16'd9,   9, 32'hCBF43926, -1, 0, 0, 0, 0, 0, 9};   // short preamble
    vecs[7]  = '{17, 16'd0,   0, 32'h00000000, -1, 1, 0, 1, 1, 0, 0};   // length 0
    vecs[8]  = '{17, 16'd65, -1, 32'h0,        -1, 0, 0, 0, 0, 1, 0};   // MAX_LEN + 1
    vecs[9]  = '{17, 16'd1,   1, 32'h83DCEFB7, -1, 1, 1, 1, 1, 0, 1};   // "1" plus pad
    vecs[10] = '{17, 16'd64, 64, 32'h00000000, -1, 1, 64, 1, 0, 0, 64}; // MAX_LEN accepted, wrong CRC

    reset = 1'b1;
    bus.bit_strobe = 1'b0;
    bus.bit_data   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("reset");

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Pulse timing: frame_start and first byte exactly on their completing strobe.
    b0 = n_bytes;
    d0 = n_done;
    repeat (17) send_bit(1'b0);
    send_bit(1'b1);
    send_byte(8'h09);
    repeat (7) send_bit(1'b0);
    chk("timing frame_start early", int'(bus.frame_start), 0);
    send_bit(1'b0);
    chk("timing frame_start", int'(bus.frame_start), 1);
    chk("timing frame_len", int'(bus.frame_len), 9);
    send_bit(1'b1);
    chk("timing frame_start width", int'(bus.frame_start), 0);
    send_byte(8'h31);
    chk("timing byte_strobe", int'(bus.byte_strobe), 1);
    chk("timing byte_data", int'(bus.byte_data), 8'h31);
    send_byte(8'h32);
    send_bit(1'b1);
    chk("timing byte_strobe on stuffing", int'(bus.byte_strobe), 0);
    send_byte(8'h33);
    send_byte(8'h34);
    send_bit(1'b1);
    send_byte(8'h35);
    repeat (2) @(posedge clk);
    #1;
    chk("midreset bytes before reset", n_bytes - b0, 5);

    // Asynchronous reset mid-frame discards it.
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_byte(8'h36);
    send_bit(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("midreset no frame_done", n_done - d0, 0);
    chk("midreset no more bytes", n_bytes - b0, 5);
    run_vec(vecs[0], "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
